// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: serializes IF fetch and MEM load/store onto one external port
// and drives the combinational pipeline advance enable `hit`. Optional watchdog: ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter bit DATA_FIRST  = 1'b1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        ext_req,
  output logic        ext_we,
  output logic [31:0] ext_addr,
  output logic [31:0] ext_wdata,
  input  logic [31:0] ext_rdata,
  input  logic        ext_ack,
  output logic        hit,
`ifdef ARB_TIMEOUT_EN
  output logic        err,
`endif
  output logic [1:0]  state_o
);

  // Handshake: ext_req/ext_we/ext_addr/ext_wdata are held constant from the first cycle of an
  // access until the posedge at which ext_ack (a single-cycle pulse) is sampled high.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        if_done_q, if_done_d;
  logic        d_done_q, d_done_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_pend, d_pend;
  logic        acc_done;
  logic [31:0] rd_val;

  assign i_pend = if_req & ~if_done_q;
  assign d_pend = (d_rd | d_wr) & ~d_done_q;
  assign hit    = ~(i_pend | d_pend);

  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign state_o  = state_q;

`ifdef ARB_TIMEOUT_EN
  logic [15:0] wait_q, wait_d;
  logic        err_q, err_d;
  logic        tmo;

  // A timed-out access completes like an ack but returns zero data.
  assign tmo      = (state_q != IDLE) && (wait_q == 16'(TIMEOUT_CYC - 1)) && !ext_ack;
  assign acc_done = ext_ack | tmo;
  assign rd_val   = tmo ? 32'd0 : ext_rdata;
  assign err      = err_q;

  always_comb begin
    err_d  = err_q | tmo;
    wait_d = 16'd0;
    if (state_q != IDLE && state_d == state_q) wait_d = wait_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= 16'd0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end
`else
  assign acc_done = ext_ack;
  assign rd_val   = ext_rdata;
`endif

  always_comb begin
    state_d    = state_q;
    if_done_d  = hit ? 1'b0 : if_done_q;
    d_done_d   = hit ? 1'b0 : d_done_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    ext_req    = 1'b0;
    ext_we     = 1'b0;
    ext_addr   = 32'd0;
    ext_wdata  = 32'd0;
    case (state_q)
      IDLE: begin
        if (d_pend && i_pend) state_d = DATA_FIRST ? D_ACC : I_ACC;
        else if (d_pend)      state_d = D_ACC;
        else if (i_pend)      state_d = I_ACC;
      end
      D_ACC: begin
        ext_req   = 1'b1;
        ext_we    = d_wr;
        ext_addr  = d_addr;
        ext_wdata = d_wdata;
        if (acc_done) begin
          if (d_rd) d_rdata_d = rd_val;
          d_done_d = 1'b1;
          state_d  = i_pend ? I_ACC : IDLE;
        end
      end
      I_ACC: begin
        ext_req  = 1'b1;
        ext_addr = if_addr;
        if (acc_done) begin
          if_rdata_d = rd_val;
          if_done_d  = 1'b1;
          state_d    = d_pend ? D_ACC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

endmodule
